muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Parametrised multiply/divide/accumulate engine with its own HI/LO registers, used by the execute stage.
//   Multiplier is pipelined with configurable depth. Divider is iterative, with a configurable number of quotient bits per cycle.
//   Adds MADD/MADDU/MSUB/MSUBU accumulate, explicit cancel, and a start/ready handshake.
//   Execute stage holds MFHI/MFLO/MTHI/MTLO while busy=1.
// PARAMETERS
//   XLEN        32  operand, HI and LO width; must be even, >=8
//   MUL_STAGES  2   multiply latency in cycles; legal range 1..4
//   DIV_BITS    1   quotient bits per divide cycle; 1 or 2; XLEN % DIV_BITS == 0
// PORTS
//   clk        in   1     clock; all state changes on rising edge
//   resetn     in   1     asynchronous reset, active-low
//   req_valid  in   1     operation request
//   req_ready  out  1     unit can accept; a request fires when req_valid && req_ready
//   req_op     in   3     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   req_x      in   XLEN  rs operand (dividend / multiplicand)
//   req_y      in   XLEN  rt operand (divisor / multiplier)
//   cancel     in   1     abort the in-flight operation (exception flush)
//   mthi_en    in   1     write HI from mt_data
//   mtlo_en    in   1     write LO from mt_data
//   mt_data    in   XLEN  MTHI/MTLO data
//   hi_o       out  XLEN  HI register
//   lo_o       out  XLEN  LO register
//   busy       out  1     operation in flight (state != IDLE)
//   done       out  1     one-cycle pulse in the cycle after HI/LO take a result
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE; hi_o, lo_o = 0; busy, done = 0; multiply pipe valid bits cleared. Applies immediately, mid-operation included.
//   req_ready = (state==IDLE) && !cancel && !mthi_en && !mtlo_en. Purely combinational; does not depend on req_valid.
//   States: IDLE, MUL, DIV, DFIX.
//     IDLE -> MUL on fire with op 0,1,4,5.
//     IDLE -> DIV on fire with op 2,3 and y != 0.
//     IDLE -> DFIX on fire with op 2,3 and y == 0.
//     MUL -> IDLE when the last pipe stage is valid.
//     DIV -> DFIX after XLEN/DIV_BITS iterations.
//     DFIX -> IDLE after one cycle.
//     Any state -> IDLE on cancel.
//   Operands are latched at fire. Later changes on req_x/req_y are ignored.
//   Multiply: signed (ops 0,4,6) or unsigned (ops 1,5,7) XLEN x XLEN -> 2*XLEN product.
//     HI/LO written at edge E0+MUL_STAGES, where E0 is the fire edge.
//     MULT/MULTU: {HI,LO} = product.
//     MADD*: {HI,LO} = {HI,LO} + product.
//     MSUB*: {HI,LO} = {HI,LO} - product.
//     All arithmetic wraps modulo 2^(2*XLEN). The accumulate uses {HI,LO} as of the write edge.
//   Divide: restoring, on operand magnitudes.
//     DIV state runs XLEN/DIV_BITS cycles. DFIX applies signs and writes HI/LO.
//     HI/LO written at edge E0 + XLEN/DIV_BITS + 1.
//     Quotient truncates toward zero. Remainder takes the dividend's sign. LO = quotient, HI = remainder.
//     Signed MIN / -1: LO = MIN, HI = 0. No trap.
//     Divide by zero (y == 0): skip DIV. DFIX writes LO = all-ones, HI = x, at edge E0+1.
//   done: registered. High for exactly one cycle after each result write edge. Never high after a cancelled operation.
//   cancel: no HI/LO write. Next edge sets state=IDLE and flushes the multiply pipe.
//     Cancel wins over a result write in the same cycle.
//     cancel in IDLE is harmless; it only blocks a fire that cycle.
//   MTHI/MTLO: honoured only in IDLE, written at the next edge. Both may be set in one cycle.
//     Ignored while busy=1; the issuer is responsible for stalling.
//   Back-to-back: a new request may fire in the cycle after done rises (state is already IDLE).
// TESTING
//   1 XLEN=32, MUL_STAGES=2: MULT x=0xFFFFFFFE, y=3 -> done at E0+2 (plus one cycle), HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   2 DIV_BITS=1: DIV x=0xFFFFFFF9 (-7), y=2 -> write at E0+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=1.
//   3 DIVU x=5, y=0 -> write at E0+1, HI=5, LO=0xFFFFFFFF. DIV x=0x80000000, y=0xFFFFFFFF -> LO=0x80000000, HI=0.
//   4 MTHI 1, MTLO 0xFFFFFFFF, then MADDU 1*1 -> HI=2, LO=0. Then MSUBU 1*1 -> HI=1, LO=0xFFFFFFFF.
//   5 DIV issued, cancel at cycle 10 -> busy=0 next edge, HI/LO unchanged, no done. MULT fires next cycle and completes normally.
//   6 Deassert resetn asynchronously mid-DIV -> hi_o=lo_o=0, busy=0 before the next clk edge. After release, req_ready=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multiply/divide/accumulate engine with private HI/LO registers.
// Pipelined multiplier (MUL_STAGES deep) and restoring divider (DIV_BITS quotient bits per cycle).
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_x,
    input  logic [XLEN-1:0] req_y,
    input  logic            cancel,
    input  logic            mthi_en,
    input  logic            mtlo_en,
    input  logic [XLEN-1:0] mt_data,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy,
    output logic            done
);
    localparam int DIV_ITERS = XLEN / DIV_BITS;
    localparam int CNT_W     = $clog2(DIV_ITERS + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_t;
    state_t r_state, w_state_next;

    logic              w_fire, w_op_mul, w_op_signed, w_fire_mul, w_fire_div, w_y_zero;
    logic              w_x_neg, w_y_neg;
    logic [XLEN-1:0]   w_x_mag, w_y_mag;
    logic [XLEN-1:0]   r_a, r_b, r_hi, r_lo;
    logic              r_sgn, r_acc, r_sub, r_dz, r_done, r_v0;
    logic [XLEN-1:0]   r_rem, r_quo, r_dvs, w_rem_it, w_quo_it;
    logic [XLEN:0]     w_sh;
    logic              r_neg_q, r_neg_r;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last_iter, w_mul_last, w_wr_mul, w_wr_div;
    logic [2*XLEN-1:0] w_ma, w_mb, w_hilo, w_mul_res, w_div_res;
    logic              w_v [MUL_STAGES];
    logic [2*XLEN-1:0] w_p [MUL_STAGES];

    // ops 0,1,4..7 multiply; 2,3 divide; even opcodes are signed
    assign w_op_mul    = req_op[2] | ~req_op[1];
    assign w_op_signed = ~req_op[0];
    assign req_ready   = (r_state == S_IDLE) & ~cancel & ~mthi_en & ~mtlo_en;
    assign w_fire      = req_valid & req_ready;
    assign w_fire_mul  = w_fire & w_op_mul;
    assign w_fire_div  = w_fire & ~w_op_mul;
    assign w_y_zero    = (req_y == '0);
    assign w_x_neg     = w_op_signed & req_x[XLEN-1];
    assign w_y_neg     = w_op_signed & req_y[XLEN-1];
    assign w_x_mag     = w_x_neg ? -req_x : req_x;
    assign w_y_mag     = w_y_neg ? -req_y : req_y;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sgn <= 1'b0;
            r_acc <= 1'b0;
            r_sub <= 1'b0;
            r_dz  <= 1'b0;
            r_v0  <= 1'b0;
        end else begin
            r_v0 <= w_fire_mul;
            if (w_fire) begin
                r_a   <= req_x;
                r_b   <= req_y;
                r_sgn <= w_op_signed;
                r_acc <= req_op[2];
                r_sub <= req_op[2] & req_op[1];
                r_dz  <= w_y_zero;
            end
        end
    end

    // Stage 0 multiplies the latched operands; later stages only carry the product.
    assign w_ma   = {{XLEN{r_sgn & r_a[XLEN-1]}}, r_a};
    assign w_mb   = {{XLEN{r_sgn & r_b[XLEN-1]}}, r_b};
    assign w_v[0] = r_v0;
    assign w_p[0] = w_ma * w_mb;

    for (genvar gi = 1; gi < MUL_STAGES; gi++) begin : g_mul_pipe
        logic              r_v;
        logic [2*XLEN-1:0] r_p;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_v <= 1'b0;
                r_p <= '0;
            end else begin
                r_v <= w_v[gi-1] & ~cancel;
                r_p <= w_p[gi-1];
            end
        end
        assign w_v[gi] = r_v;
        assign w_p[gi] = r_p;
    end

    assign w_mul_last = w_v[MUL_STAGES-1];

    always_comb begin
        w_rem_it = r_rem;
        w_quo_it = r_quo;
        w_sh     = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            w_sh     = {w_rem_it, w_quo_it[XLEN-1]};
            w_quo_it = {w_quo_it[XLEN-2:0], 1'b0};
            if (w_sh >= {1'b0, r_dvs}) begin
                w_sh        = w_sh - {1'b0, r_dvs};
                w_quo_it[0] = 1'b1;
            end
            w_rem_it = w_sh[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
        end else if (w_fire_div) begin
            r_rem   <= '0;
            r_quo   <= w_x_mag;
            r_dvs   <= w_y_mag;
            r_neg_q <= w_x_neg ^ w_y_neg;
            r_neg_r <= w_x_neg;
            r_cnt   <= '0;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_it;
            r_quo <= w_quo_it;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_last_iter = (r_cnt == CNT_W'(DIV_ITERS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_fire) w_state_next = w_op_mul ? S_MUL : (w_y_zero ? S_DFIX : S_DIV);
            S_MUL:  if (w_mul_last) w_state_next = S_IDLE;
            S_DIV:  if (w_last_iter) w_state_next = S_DFIX;
            S_DFIX: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (cancel) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Cancel suppresses a result write landing in the same cycle.
    assign w_wr_mul  = (r_state == S_MUL) & w_mul_last & ~cancel;
    assign w_wr_div  = (r_state == S_DFIX) & ~cancel;
    assign w_hilo    = {r_hi, r_lo};
    assign w_mul_res = !r_acc ? w_p[MUL_STAGES-1] :
                       (r_sub ? w_hilo - w_p[MUL_STAGES-1] : w_hilo + w_p[MUL_STAGES-1]);
    assign w_div_res = r_dz ? {r_a, {XLEN{1'b1}}} :
                       {(r_neg_r ? -r_rem : r_rem), (r_neg_q ? -r_quo : r_quo)};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_wr_mul | w_wr_div;
            if (w_wr_mul) begin
                {r_hi, r_lo} <= w_mul_res;
            end else if (w_wr_div) begin
                {r_hi, r_lo} <= w_div_res;
            end else if (r_state == S_IDLE) begin
                if (mthi_en) r_hi <= mt_data;
                if (mtlo_en) r_lo <= mt_data;
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and completion cycle are queued at issue
// and checked by an independent monitor whenever done pulses.
module tb_muldiv_unit;
    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int DIV_BITS   = 1;
    localparam int DIV_LAT    = XLEN / DIV_BITS + 1;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid, req_ready, cancel, mthi_en, mtlo_en, busy, done;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_x, req_y, mt_data, hi_o, lo_o;

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(DIV_BITS)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y), .cancel(cancel),
        .mthi_en(mthi_en), .mtlo_en(mtlo_en), .mt_data(mt_data),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hilo;
        int          cyc;
    } exp_t;
    exp_t        sb_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic straight from the operation definitions.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, y,
                                          input logic [63:0] hilo);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0]        p;
        sa = $signed(x);
        sb = $signed(y);
        if (op == 3'd2 || op == 3'd3) begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (op == 3'd2) begin
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            return {x % y, x / y};
        end
        if (op[0] == 1'b0) p = sa * sb;
        else               p = {32'd0, x} * {32'd0, y};
        if (op == 3'd0 || op == 3'd1) return p;
        if (op == 3'd4 || op == 3'd5) return hilo + p;
        return hilo - p;
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] y);
        if (op == 3'd2 || op == 3'd3) return (y == 32'd0) ? 1 : DIV_LAT;
        return MUL_STAGES;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    always @(negedge clk) begin
        if (resetn && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_hilo", {hi_o, lo_o}, mon_e.hilo);
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] x, y, input int cancel_k);
        int          c;
        logic [63:0] e;
        exp_t        t;
        @(negedge clk); #1;
        for (int k = 0; k < 300 && !req_ready; k++) begin
            @(negedge clk); #1;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 300 cycles");
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        c         = cyc;
        e         = model(op, x, y, {m_hi, m_lo});
        @(negedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_x     = $urandom;
        req_y     = $urandom;
        if (cancel_k < 0) begin
            t.hilo = e;
            t.cyc  = c + 1 + lat(op, y);
            sb_q.push_back(t);
            {m_hi, m_lo} = e;
        end else begin
            repeat (cancel_k) begin
                @(negedge clk); #1;
            end
            cancel = 1'b1;
            @(negedge clk); #1;
            cancel = 1'b0;
            chk("cancel_busy", 64'(busy), 64'd0);
            chk("cancel_done", 64'(done), 64'd0);
            chk("cancel_hilo", {hi_o, lo_o}, {m_hi, m_lo});
        end
    endtask

    task automatic mt(input logic he, le, input logic [31:0] d);
        @(negedge clk); #1;
        for (int k = 0; k < 300 && busy; k++) begin
            @(negedge clk); #1;
        end
        mthi_en = he;
        mtlo_en = le;
        mt_data = d;
        #1;
        if (he || le) chk("ready_blocked_by_mt", 64'(req_ready), 64'd0);
        if (he) m_hi = d;
        if (le) m_lo = d;
        @(negedge clk); #1;
        mthi_en = 1'b0;
        mtlo_en = 1'b0;
        chk("mt_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] x, y;
        int          r, ck;
        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
        cancel = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0; mt_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        resetn = 1'b1;
        #1;
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, -1); drain();
        chk("t1_mult", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, -1); drain();
        chk("t2_div", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, -1); drain();
        chk("t2_divu", {hi_o, lo_o}, 64'h0000_0001_7FFF_FFFC);
        issue(3'd3, 32'd5, 32'd0, -1); drain();
        chk("t3_divzero", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1); drain();
        chk("t3_min_div_m1", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        mt(1'b1, 1'b0, 32'd1);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        issue(3'd5, 32'd1, 32'd1, -1); drain();
        chk("t4_maddu", {hi_o, lo_o}, 64'h0000_0002_0000_0000);
        issue(3'd7, 32'd1, 32'd1, -1); drain();
        chk("t4_msubu", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);

        // Cancel mid-divide, then a MULT straight after.
        issue(3'd2, 32'd1000, 32'd7, 9);
        issue(3'd0, 32'h1234_5678, 32'hFFFF_FF00, -1); drain();
        // Cancel landing on the write edge of a MADD and of a divide-by-zero.
        issue(3'd4, 32'd77, 32'd99, MUL_STAGES - 1);
        issue(3'd3, 32'd9, 32'd0, 0);

        // Cancel in IDLE blocks a fire.
        @(negedge clk); #1;
        cancel = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_x = 32'd3; req_y = 32'd3;
        #1;
        chk("ready_cancel_idle", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk("cancel_idle_busy", 64'(busy), 64'd0);
        cancel = 1'b0; req_valid = 1'b0;

        // MTHI/MTLO while busy are ignored.
        issue(3'd2, 32'd1000, 32'd7, -1);
        mthi_en = 1'b1; mtlo_en = 1'b1; mt_data = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        mthi_en = 1'b0; mtlo_en = 1'b0;
        drain();
        chk("mt_ignored_busy", {hi_o, lo_o}, {m_hi, m_lo});

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                op = 3'($urandom);
                x  = pick();
                y  = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
                ck = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, lat(op, y) - 1)) : -1;
                issue(op, x, y, ck);
            end
        end
        drain();

        // Asynchronous reset in the middle of a divide.
        mt(1'b1, 1'b1, 32'hA5A5_A5A5);
        issue(3'd3, 32'hFFFF_0000, 32'd3, -1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        sb_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk); #1;
        resetn = 1'b1;
        #1;
        chk("ready_after_async_reset", 64'(req_ready), 64'd1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
